// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: memory word, RAM status encoding and the arbiter's state set.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IRD  = 2'd1,
    DRD  = 2'd2,
    DWR  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter serving icache reads and dcache reads/writes, with
// round-robin fairness for the icache, an error counter and a transaction watchdog.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WDOG_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        timeout,
  output logic [7:0]  errcnt
);

  localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_CYCLES);

  arb_state_t  state_q, state_d;
  word_t       addr_q, addr_d;
  word_t       data_q, data_d;
  logic        ifair_q, ifair_d;
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  errcnt_q, errcnt_d;

  ramstate_t   rs;
  logic        owner_req;
  logic        done;

  assign rs = ramstate_t'(ramstate);

  always_comb begin
    owner_req = 1'b0;
    case (state_q)
      IRD:     owner_req = iREN;
      DRD:     owner_req = dREN;
      DWR:     owner_req = dWEN;
      default: owner_req = 1'b0;
    endcase
  end

  // A withdrawn request never completes, even if the RAM answers in that cycle.
  assign done = (state_q != IDLE) && owner_req && (rs == ACCESS);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    ifair_d   = ifair_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    errcnt_d  = errcnt_q;

    if (state_q == IDLE) begin
      if (ifair_q && iREN) begin
        state_d = IRD;
        addr_d  = iaddr;
        ifair_d = 1'b0;
        cnt_d   = '0;
      end else if (dWEN) begin
        state_d = DWR;
        addr_d  = daddr;
        data_d  = dstore;
        cnt_d   = '0;
      end else if (dREN) begin
        state_d = DRD;
        addr_d  = daddr;
        cnt_d   = '0;
      end else if (iREN) begin
        state_d = IRD;
        addr_d  = iaddr;
        ifair_d = 1'b0;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q + 16'd1;
      if (!owner_req) begin
        state_d = IDLE;
      end else if (rs == ACCESS) begin
        state_d = IDLE;
        if (state_q != IRD && iREN) ifair_d = 1'b1;
      end else if (rs == ERROR) begin
        state_d = IDLE;
        if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
      end else if (cnt_d >= WDOG_LIMIT) begin
        state_d   = IDLE;
        timeout_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  // NOTE: the state flop resets asynchronously, so the RAM strobes fall the instant nRST goes low.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      ifair_q   <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      errcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ifair_q   <= ifair_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      errcnt_q  <= errcnt_d;
    end
  end

  assign ramREN   = (state_q == IRD) || (state_q == DRD);
  assign ramWEN   = (state_q == DWR);
  assign ramaddr  = addr_q;
  assign ramstore = data_q;

  assign iwait = !(done && state_q == IRD);
  assign dwait = !(done && (state_q == DRD || state_q == DWR));
  assign iload = ramload;
  assign dload = ramload;

  assign timeout = timeout_q;
  assign errcnt  = errcnt_q;

endmodule
